// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed display scanner with double-buffered display data,
// frame-synchronous commit and per-digit blinking.
module disp_scan_ctrl #(
  parameter int SCAN_CNT     = 50000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic [3:0]  pin,
  input  logic [3:0]  len,
  input  logic [3:0]  ben,
  input  logic        load,
  output logic        ack,
  output logic [3:0]  AN,
  output logic [3:0]  D,
  output logic        LE,
  output logic        point,
  output logic        frame
);

  localparam int CW = (SCAN_CNT > 2) ? $clog2(SCAN_CNT) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_CNT - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [15:0] din;
    logic [3:0]  pin;
    logic [3:0]  len;
    logic [3:0]  ben;
  } disp_regs_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          phase_q, phase_d;
  logic          pend_q, pend_d;
  disp_regs_t    stg_q, stg_d;
  disp_regs_t    act_q, act_d;
  logic          ack_q, ack_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    dig_q, dig_d;
  logic          le_q, le_d;
  logic          pt_q, pt_d;

  logic tick;
  logic frame_w;
  logic vis;

  assign tick    = (cnt_q == CNT_MAX);
  assign frame_w = tick && (idx_q == 2'd3);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    blk_d   = blk_q;
    phase_d = phase_q;
    pend_d  = pend_q;
    stg_d   = stg_q;
    act_d   = act_q;
    ack_d   = 1'b0;

    if (frame_w) begin
      if (blk_q == BLK_MAX) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d = blk_q + BW'(1);
      end
    end

    // A commit takes priority over a coincident load; the load is dropped
    // because staging is still occupied in that cycle.
    if (frame_w && pend_q) begin
      act_d  = stg_q;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end else if (load && !pend_q) begin
      stg_d  = '{din: din, pin: pin, len: len, ben: ben};
      pend_d = 1'b1;
    end

    vis   = act_q.len[idx_q] && !(act_q.ben[idx_q] && phase_q);
    an_d  = vis ? ~(4'b0001 << idx_q) : 4'b1111;
    dig_d = act_q.din[idx_q*4 +: 4];
    le_d  = ~vis;
    pt_d  = vis && act_q.pin[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b0;
      pend_q  <= 1'b0;
      // NOTE: the data registers are reset too, so a display enabled right
      // after reset shows a defined blank pattern instead of power-up junk.
      stg_q   <= '0;
      act_q   <= '0;
      ack_q   <= 1'b0;
      an_q    <= 4'b1111;
      dig_q   <= '0;
      le_q    <= 1'b1;
      pt_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      stg_q   <= stg_d;
      act_q   <= act_d;
      ack_q   <= ack_d;
      an_q    <= an_d;
      dig_q   <= dig_d;
      le_q    <= le_d;
      pt_q    <= pt_d;
    end
  end

  assign ack   = ack_q;
  assign AN    = an_q;
  assign D     = dig_q;
  assign LE    = le_q;
  assign point = pt_q;
  assign frame = frame_w;

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_CNT, default 50000, meaning clock cycles each digit is shown (legal range >= 2).
REQ-002 The block SHALL have parameter BLINK_FRAMES, default 32, meaning full scan frames per blink half-period (legal range >= 1).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low: ports clk and rst_n.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 din  input  16  hex value to show; digit k is din[4k+3:4k], with k=0 the rightmost digit.
REQ-007 pin  input  4  per-digit decimal-point request; bit k goes to digit k.
REQ-008 len  input  4  per-digit enable; 1 means the digit is shown.
REQ-009 ben  input  4  per-digit blink enable.
REQ-010 load  input  1  request to capture din/pin/len/ben.
REQ-011 ack  output  1  one-cycle pulse when captured data becomes visible.
REQ-012 AN  output  4  digit anodes, active-low, one-hot.
REQ-013 D  output  4  hex code for the decoder D3..D0.
REQ-014 LE  output  1  decoder blank; 1 means blank.
REQ-015 point  output  1  decoder point input.
REQ-016 frame  output  1  one-cycle pulse at end of each scan frame.

Function
REQ-017 The prescaler SHALL count 0..SCAN_CNT-1 and wrap; tick asserts in the cycle where the count equals SCAN_CNT-1.
REQ-018 Digit index idx SHALL advance 0->1->2->3->0 on tick.
REQ-019 frame SHALL equal tick AND idx==3.
REQ-020 The block SHALL hold separate staging and active register sets for din/pin/len/ben, plus a pending flag.
REQ-021 load with pending=0 SHALL capture all four inputs into staging and set pending on the next edge.
REQ-022 load with pending=1 SHALL be ignored: staging is unchanged and there is no error indication.
REQ-023 On frame with pending=1, the block SHALL copy staging to active, clear pending, and pulse ack for exactly the following cycle.
REQ-024 Simultaneous load and frame with pending=1 SHALL commit the old staging and drop the new load.
REQ-025 Simultaneous load and frame with pending=0 SHALL capture into staging and commit at the next frame, not the current one.
REQ-026 The blink counter SHALL count frames 0..BLINK_FRAMES-1; on wrap it toggles phase.
REQ-027 A digit k is visible iff active len[k]=1 AND NOT (active ben[k]=1 AND phase=1).
REQ-028 AN SHALL drive bit idx low only when digit idx is visible, otherwise 4'b1111.
REQ-029 D SHALL equal active din[4*idx+3:4*idx].
REQ-030 point SHALL equal active pin[idx] when the digit is visible, else 0.
REQ-031 LE SHALL equal NOT visible(idx).
REQ-032 AN, D, LE and point SHALL be registered and update one cycle after idx/phase/active change.
REQ-033 Display data SHALL change only at frame boundaries; no torn frames are permitted.

Reset
REQ-034 rst_n=0 SHALL immediately force the following, independent of clk:
- prescaler=0, idx=0, phase=0, blink count=0, pending=0;
- staging and active registers all 0;
- AN=4'b1111, D=0, LE=1, point=0, ack=0, frame=0.
REQ-035 Reset asserted mid-frame or with pending=1 SHALL discard the staged data; the first frame pulse after release occurs 4*SCAN_CNT cycles later.

Verification
REQ-036 The bench SHALL run the following directed scenarios with SCAN_CNT=4 and BLINK_FRAMES=2:
- Scan: after reset, load din=16'h1234, len=4'hF, ben=0, pin=4'b0100 -> ack after first frame; thereafter AN cycles 1110,1101,1011,0111 every 4 clocks with D=4,3,2,1, point=1 only while AN=1011, LE=0.
- Back-pressure: load 16'hAAAA, then load 16'h5555 before frame -> commit shows AAAA; 5555 never appears; exactly one ack.
- Boundary: load coincident with frame, pending=0 -> value is not visible in the next frame; it becomes visible one frame later with ack.
- Blink: len=4'hF, ben=4'b0001 -> digit 0 shows for 2 frames and is blanked for 2 frames (AN=1111, LE=1 in its slot); other digits are unaffected.
- Disable: len=4'b0000 -> AN stays 1111 and LE=1 throughout; frame keeps pulsing every 16 cycles.
- Async reset: assert rst_n=0 mid-digit with pending=1 -> outputs go to reset values without a clock edge; no ack after release until a new load.
